// File: rtl/maze_probe.sv
// maze_probe -- sequential maze-neighbourhood sampler.
//
// On a start pulse the object's centre (objectX, objectY) and half-size
// (objectS) are latched. Five probes are then read, one after another, from
// the shared synchronous 1-bit maze ROM: the centre, and one pixel beyond the
// top, bottom, left and right edges. All five results are presented together
// on the Maze* outputs, and valid pulses for one cycle at that point.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous, active-high
//   start        request pulse, only sampled while idle
//   objectX/Y    object centre in pixels (unsigned, 10 bit)
//   objectS      object half-size in pixels (unsigned, 10 bit)
//   rom_addr     registered maze ROM address, (row * GRID_W + col)
//   rom_data     ROM read data, valid one cycle after rom_addr; 1 = wall
//   currentMaze, MazeUp, MazeDown, MazeLeft, MazeRight
//                registered probe results
//   busy         a probe sequence is in flight
//   valid        one-cycle pulse when the results have just been updated
//
// Build option: MAZE_PROBE_EDGE_WALL_EN
//   defined   - a probe that falls outside the 640x480 field reads as wall.
//               Its clamped address is still issued and the ROM data is ignored.
//   undefined - out-of-range probes are clamped to the field edge, and the
//               ROM bit of the clamped cell is used.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs and rom_addr hold their values
// RUN   | issuing probe addresses k1..k4 and capturing returned data
// LAST  | final ROM bit arrives; commit all results and pulse valid
module maze_probe #(
  parameter int CELL_SHIFT = 3,
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int ADDR_W     = 13
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        objectX,
  input  logic [9:0]        objectY,
  input  logic [9:0]        objectS,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              currentMaze,
  output logic              MazeUp,
  output logic              MazeDown,
  output logic              MazeLeft,
  output logic              MazeRight,
  output logic              busy,
  output logic              valid
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  localparam logic [11:0] X_MAX = 12'((GRID_W << CELL_SHIFT) - 1);
  localparam logic [11:0] Y_MAX = 12'((GRID_H << CELL_SHIFT) - 1);

  state_t            state_q;
  logic [9:0]        x_q, y_q, s_q;
  logic [2:0]        cnt_q;      // index of the next address to issue
  logic [3:0]        shadow_q;   // results of probes k0..k3
  logic [4:0]        res_q;      // {right, left, down, up, centre}
  logic [ADDR_W-1:0] rom_addr_q;
  logic              busy_q;
  logic              valid_q;

  // Probe coordinate generation. The k0 address is issued on the same edge
  // that latches the inputs, so while idle the raw inputs feed the datapath.
  logic [9:0]        bx, by, bs;
  logic [2:0]        k;
  logic [11:0]       d, px, py, cx, cy;
  logic [ADDR_W-1:0] addr_c;
  logic              probe_bit;

`ifdef MAZE_PROBE_EDGE_WALL_EN
  logic [4:0] oor_q;
  logic       oor_c;
`endif

  always_comb begin
    if (state_q == IDLE) begin
      bx = objectX;
      by = objectY;
      bs = objectS;
      k  = 3'd0;
    end else begin
      bx = x_q;
      by = y_q;
      bs = s_q;
      k  = cnt_q;
    end
    d  = {2'b00, bs} + 12'd1;
    px = {2'b00, bx};
    py = {2'b00, by};
    case (k)
      3'd1:    py = py - d;
      3'd2:    py = py + d;
      3'd3:    px = px - d;
      3'd4:    px = px + d;
      default: ;
    endcase
    // Max reachable value is 1023+1023+1 = 2047, so bit 11 is a pure sign bit.
    cx = px[11] ? 12'd0 : ((px > X_MAX) ? X_MAX : px);
    cy = py[11] ? 12'd0 : ((py > Y_MAX) ? Y_MAX : py);
    addr_c = ADDR_W'(cy >> CELL_SHIFT) * ADDR_W'(GRID_W) + ADDR_W'(cx >> CELL_SHIFT);
  end

`ifdef MAZE_PROBE_EDGE_WALL_EN
  assign oor_c = px[11] | py[11] | (px > X_MAX) | (py > Y_MAX);
  // cnt_q - 2 is the probe whose data is on rom_data now (LAST: cnt_q = 6 -> 4).
  assign probe_bit = oor_q[cnt_q - 3'd2] | rom_data;
`else
  assign probe_bit = rom_data;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      res_q      <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef MAZE_PROBE_EDGE_WALL_EN
      oor_q      <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q        <= objectX;
            y_q        <= objectY;
            s_q        <= objectS;
            rom_addr_q <= addr_c;
`ifdef MAZE_PROBE_EDGE_WALL_EN
            oor_q[0]   <= oor_c;
`endif
            cnt_q      <= 3'd1;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (cnt_q <= 3'd4) begin
            rom_addr_q    <= addr_c;
`ifdef MAZE_PROBE_EDGE_WALL_EN
            oor_q[cnt_q]  <= oor_c;
`endif
          end
          // Data lags the address by two edges: cnt 2..5 -> shadow 0..3.
          if (cnt_q >= 3'd2) begin
            shadow_q[cnt_q[1:0] - 2'd2] <= probe_bit;
          end
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            state_q <= LAST;
          end
        end
        LAST: begin
          res_q   <= {probe_bit, shadow_q};
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign currentMaze = res_q[0];
  assign MazeUp      = res_q[1];
  assign MazeDown    = res_q[2];
  assign MazeLeft    = res_q[3];
  assign MazeRight   = res_q[4];
  assign busy        = busy_q;
  assign valid       = valid_q;

endmodule
